// File: rtl/uart_tx_fifo.sv
// UART transmitter with a synchronous TX FIFO, run-time frame format and baud divisor.
// Frame configuration is captured when a word is popped, so mid-frame input changes do not disturb the line.
module uart_tx_fifo #(
   parameter int DATA_W       = 8,
   parameter int BITCNT_WIDTH = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter int DIV_WIDTH    = 16
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             en,
   input  logic [DIV_WIDTH-1:0]             baud_div,
   input  logic [BITCNT_WIDTH-1:0]          trans_len,
   input  logic                             parity_en,
   input  logic                             parity_type,
   input  logic                             stop2,
   input  logic [DATA_W-1:0]                tx_data,
   input  logic                             tx_valid,
   output logic                             tx_ready,
   output logic                             tx,
   output logic                             tx_busy,
   output logic                             tx_done,
   output logic                             tx_err,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH+1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [DATA_W-1:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [LVL_W-1:0]        r_level;

   logic [2:0]              r_state;
   logic [DATA_W-1:0]       r_shift;
   logic [BITCNT_WIDTH-1:0] r_bit_cnt;
   logic [BITCNT_WIDTH-1:0] r_len;
   logic                    r_par_en;
   logic                    r_parity;
   logic                    r_stop2;
   logic                    r_stop_cnt;
   logic [DIV_WIDTH-1:0]    r_div;
   logic [DIV_WIDTH-1:0]    r_timer;
   logic                    r_tx;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;

   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_tick;
   logic                    w_frame_end;
   logic [BITCNT_WIDTH-1:0] w_len_eff;
   logic [DATA_W-1:0]       w_mask;
   logic [DATA_W-1:0]       w_head;

   assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_empty     = (r_level == '0);
   assign w_push      = tx_valid && !w_full;
   assign w_tick      = (r_state != S_IDLE) && (r_timer == '0);
   assign w_frame_end = (r_state == S_STOP) && w_tick && (!r_stop2 || r_stop_cnt);
   // A pop at frame end chains the next start bit directly onto the last stop bit.
   assign w_pop       = en && !w_empty && ((r_state == S_IDLE) || w_frame_end);
   assign w_head      = r_mem[r_rd_ptr] & w_mask;

   assign tx_ready    = !w_full;
   assign tx          = r_tx;
   assign tx_busy     = r_busy;
   assign tx_done     = r_done;
   assign tx_err      = r_err;
   assign fifo_level  = r_level;

   always_comb begin
      w_len_eff = trans_len;
      if (trans_len < BITCNT_WIDTH'(5))
         w_len_eff = BITCNT_WIDTH'(5);
      else if (trans_len > BITCNT_WIDTH'(DATA_W))
         w_len_eff = BITCNT_WIDTH'(DATA_W);
      w_mask = '0;
      for (int i = 0; i < DATA_W; i++)
         w_mask[i] = (i < int'(w_len_eff));
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)
            r_level <= r_level + LVL_W'(1);
         else if (!w_push && w_pop)
            r_level <= r_level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_len      <= '0;
         r_par_en   <= 1'b0;
         r_parity   <= 1'b0;
         r_stop2    <= 1'b0;
         r_stop_cnt <= 1'b0;
         r_div      <= '0;
         r_timer    <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= tx_valid && w_full;
         if (w_pop) begin
            r_shift    <= w_head;
            r_len      <= w_len_eff;
            r_par_en   <= parity_en;
            r_parity   <= (^w_head) ^ parity_type;
            r_stop2    <= stop2;
            r_div      <= baud_div;
            r_timer    <= baud_div;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= w_frame_end;
         end else if (w_frame_end) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
         end else if (r_state != S_IDLE) begin
            if (r_timer != '0) begin
               r_timer <= r_timer - DIV_WIDTH'(1);
            end else begin
               r_timer <= r_div;
               case (r_state)
                  S_START: begin
                     r_state   <= S_DATA;
                     r_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                     r_bit_cnt <= BITCNT_WIDTH'(1);
                  end
                  S_DATA: begin
                     if (r_bit_cnt == r_len) begin
                        r_state <= r_par_en ? S_PARITY : S_STOP;
                        r_tx    <= r_par_en ? r_parity : 1'b1;
                     end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + BITCNT_WIDTH'(1);
                     end
                  end
                  S_PARITY: begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end
                  S_STOP: begin
                     r_stop_cnt <= 1'b1;
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: frame format, FIFO full/drop, clamping, en drop, reset.
module tb_uart_tx_fifo;

   logic        clk;
   logic        rstn;
   logic        en;
   logic [15:0] baud_div;
   logic [3:0]  trans_len;
   logic        parity_en;
   logic        parity_type;
   logic        stop2;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx;
   logic        tx_busy;
   logic        tx_done;
   logic        tx_err;
   logic [3:0]  fifo_level;

   int total;
   int bad;
   logic [511:0] wv_tx;
   logic [511:0] wv_busy;
   logic [511:0] wv_done;

   uart_tx_fifo #(
      .DATA_W(8), .BITCNT_WIDTH(4), .FIFO_DEPTH(8), .DIV_WIDTH(16)
   ) dut (
      .clk(clk), .rstn(rstn), .en(en), .baud_div(baud_div), .trans_len(trans_len),
      .parity_en(parity_en), .parity_type(parity_type), .stop2(stop2),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err), .fifo_level(fifo_level)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   // Reference waveform of one frame, p cycles per bit, placed at cycle offset off.
   function automatic logic [511:0] add_frame(input logic [511:0] w, input int off, input logic [7:0] d,
                                               input int len, input bit pe, input bit pt, input bit s2, input int p);
      logic [511:0] r;
      bit par;
      int nb;
      logic v;
      r   = w;
      par = pt;
      nb  = 1 + len + int'(pe) + 1 + int'(s2);
      for (int b = 0; b < nb; b++) begin
         if (b == 0) v = 1'b0;
         else if (b <= len) begin
            v   = d[b-1];
            par = par ^ v;
         end
         else if (pe && b == len + 1) v = par;
         else v = 1'b1;
         for (int k = 0; k < p; k++) r[off + b*p + k] = v;
      end
      return r;
   endfunction

   task automatic push(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic record(input int n);
      wv_tx   = '1;
      wv_busy = '0;
      wv_done = '0;
      for (int i = 0; i < n; i++) begin
         if (i != 0) @(negedge clk);
         wv_tx[i]   = tx;
         wv_busy[i] = tx_busy;
         wv_done[i] = tx_done;
      end
   endtask

   task automatic wait_tx_low(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (tx === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      total++; if (tx !== 1'b1)        begin bad++; $display("[TB] FAIL reset_tx got=%b exp=1", tx); end
      total++; if (tx_busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", tx_busy); end
      total++; if (tx_done !== 1'b0)   begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", tx_done); end
      total++; if (tx_err !== 1'b0)    begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", tx_err); end
      total++; if (fifo_level !== 4'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d exp=0", fifo_level); end
      total++; if (tx_ready !== 1'b1)  begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", tx_ready); end
   endtask

   task automatic test_basic_frame;
      logic [511:0] exp_tx, exp_busy, exp_done;
      baud_div = 16'd3; trans_len = 4'd8; parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0; en = 1'b1;
      push(8'hA5);
      total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL basic_pre_start got=%b exp=1", tx); end
      @(negedge clk);
      total++; if (tx !== 1'b0) begin bad++; $display("[TB] FAIL basic_latency got=%b exp=0", tx); end
      record(44);
      exp_tx   = add_frame('1, 0, 8'hA5, 8, 1'b0, 1'b0, 1'b0, 4);
      exp_busy = '0;
      for (int i = 0; i < 40; i++) exp_busy[i] = 1'b1;
      exp_done = '0;
      exp_done[40] = 1'b1;
      total++; if (wv_tx !== exp_tx)     begin bad++; $display("[TB] FAIL basic_tx got=%h exp=%h", wv_tx[63:0], exp_tx[63:0]); end
      total++; if (wv_busy !== exp_busy) begin bad++; $display("[TB] FAIL basic_busy got=%h exp=%h", wv_busy[63:0], exp_busy[63:0]); end
      total++; if (wv_done !== exp_done) begin bad++; $display("[TB] FAIL basic_done got=%h exp=%h", wv_done[63:0], exp_done[63:0]); end
   endtask

   task automatic test_parity(input bit pt);
      logic [511:0] exp_tx, exp_done;
      bit ok;
      baud_div = 16'd1; trans_len = 4'd7; parity_en = 1'b1; parity_type = pt; stop2 = 1'b1; en = 1'b1;
      push(8'h55);
      wait_tx_low(4, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL parity_start got=timeout exp=start"); end
      record(24);
      exp_tx   = add_frame('1, 0, 8'h55, 7, 1'b1, pt, 1'b1, 2);
      exp_done = '0;
      exp_done[22] = 1'b1;
      total++; if (wv_tx[16] !== pt)     begin bad++; $display("[TB] FAIL parity_bit got=%b exp=%b", wv_tx[16], pt); end
      total++; if (wv_tx !== exp_tx)     begin bad++; $display("[TB] FAIL parity_tx got=%h exp=%h", wv_tx[31:0], exp_tx[31:0]); end
      total++; if (wv_done !== exp_done) begin bad++; $display("[TB] FAIL parity_done got=%h exp=%h", wv_done[31:0], exp_done[31:0]); end
   endtask

   task automatic test_fifo_full;
      logic [511:0] exp_tx, exp_done;
      bit ok;
      en = 1'b0; baud_div = 16'd0; trans_len = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tx_data  = 8'(i);
         tx_valid = 1'b1;
         @(negedge clk);
         if (i == 8) begin
            total++; if (fifo_level !== 4'd8) begin bad++; $display("[TB] FAIL full_level got=%0d exp=8", fifo_level); end
            total++; if (tx_ready !== 1'b0)   begin bad++; $display("[TB] FAIL full_ready got=%b exp=0", tx_ready); end
            total++; if (tx_err !== 1'b0)     begin bad++; $display("[TB] FAIL full_err_early got=%b exp=0", tx_err); end
         end
         if (i == 9) begin
            total++; if (tx_err !== 1'b1)     begin bad++; $display("[TB] FAIL drop_err got=%b exp=1", tx_err); end
            total++; if (fifo_level !== 4'd8) begin bad++; $display("[TB] FAIL drop_level got=%0d exp=8", fifo_level); end
         end
      end
      tx_valid = 1'b0;
      @(negedge clk);
      total++; if (tx_err !== 1'b0) begin bad++; $display("[TB] FAIL drop_err_pulse got=%b exp=0", tx_err); end
      en = 1'b1;
      wait_tx_low(4, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_start got=timeout exp=start"); end
      record(84);
      exp_tx   = '1;
      exp_done = '0;
      for (int f = 0; f < 8; f++) begin
         exp_tx = add_frame(exp_tx, f*10, 8'(f+1), 8, 1'b0, 1'b0, 1'b0, 1);
         exp_done[(f+1)*10] = 1'b1;
      end
      total++; if (wv_tx !== exp_tx)     begin bad++; $display("[TB] FAIL b2b_tx got=%h exp=%h", wv_tx[95:0], exp_tx[95:0]); end
      total++; if (wv_done !== exp_done) begin bad++; $display("[TB] FAIL b2b_done got=%h exp=%h", wv_done[95:0], exp_done[95:0]); end
      total++; if (fifo_level !== 4'd0)  begin bad++; $display("[TB] FAIL b2b_level got=%0d exp=0", fifo_level); end
   endtask

   task automatic test_clamp;
      logic [511:0] exp_tx, exp_done;
      bit ok;
      en = 1'b1; baud_div = 16'd0; parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0;
      trans_len = 4'd3;
      push(8'h60);
      wait_tx_low(4, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL clamp_lo_start got=timeout exp=start"); end
      record(12);
      exp_tx   = add_frame('1, 0, 8'h60, 5, 1'b0, 1'b0, 1'b0, 1);
      exp_done = '0;
      exp_done[7] = 1'b1;
      total++; if (wv_tx !== exp_tx)     begin bad++; $display("[TB] FAIL clamp_lo_tx got=%h exp=%h", wv_tx[15:0], exp_tx[15:0]); end
      total++; if (wv_done !== exp_done) begin bad++; $display("[TB] FAIL clamp_lo_done got=%h exp=%h", wv_done[15:0], exp_done[15:0]); end
      trans_len = 4'd15;
      push(8'h3C);
      wait_tx_low(4, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL clamp_hi_start got=timeout exp=start"); end
      trans_len = 4'd5; parity_en = 1'b1; stop2 = 1'b1; baud_div = 16'd5;
      record(14);
      exp_tx   = add_frame('1, 0, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 1);
      exp_done = '0;
      exp_done[10] = 1'b1;
      total++; if (wv_tx !== exp_tx)     begin bad++; $display("[TB] FAIL clamp_hi_tx got=%h exp=%h", wv_tx[15:0], exp_tx[15:0]); end
      total++; if (wv_done !== exp_done) begin bad++; $display("[TB] FAIL clamp_hi_done got=%h exp=%h", wv_done[15:0], exp_done[15:0]); end
      parity_en = 1'b0; stop2 = 1'b0; baud_div = 16'd0; trans_len = 4'd8;
   endtask

   task automatic test_en_drop;
      logic [511:0] exp_tx;
      bit ok;
      bit seen_low;
      int cyc;
      en = 1'b0; baud_div = 16'd1; trans_len = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
      push(8'h3C);
      push(8'hC3);
      total++; if (fifo_level !== 4'd2) begin bad++; $display("[TB] FAIL endrop_queued got=%0d exp=2", fifo_level); end
      en = 1'b1;
      wait_tx_low(4, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL endrop_start got=timeout exp=start"); end
      total++; if (fifo_level !== 4'd1) begin bad++; $display("[TB] FAIL endrop_popped got=%0d exp=1", fifo_level); end
      repeat (6) @(negedge clk);
      total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL endrop_bit2 got=%b exp=1", tx); end
      en = 1'b0;
      cyc = 0;
      ok  = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (tx_done === 1'b1) begin
            cyc = i;
            ok  = 1'b1;
            break;
         end
      end
      total++; if (!ok || cyc != 14) begin bad++; $display("[TB] FAIL endrop_done_at got=%0d exp=14", cyc); end
      seen_low = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) seen_low = 1'b1;
      end
      total++; if (seen_low)            begin bad++; $display("[TB] FAIL endrop_idle got=low exp=high"); end
      total++; if (fifo_level !== 4'd1) begin bad++; $display("[TB] FAIL endrop_kept got=%0d exp=1", fifo_level); end
      total++; if (tx_busy !== 1'b0)    begin bad++; $display("[TB] FAIL endrop_busy got=%b exp=0", tx_busy); end
      en = 1'b1;
      wait_tx_low(4, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL endrop_resume got=timeout exp=start"); end
      record(22);
      exp_tx = add_frame('1, 0, 8'hC3, 8, 1'b0, 1'b0, 1'b0, 2);
      total++; if (wv_tx !== exp_tx)    begin bad++; $display("[TB] FAIL endrop_frame2 got=%h exp=%h", wv_tx[31:0], exp_tx[31:0]); end
      total++; if (fifo_level !== 4'd0) begin bad++; $display("[TB] FAIL endrop_empty got=%0d exp=0", fifo_level); end
   endtask

   task automatic test_reset_midframe;
      bit ok;
      bit seen_low;
      bit seen_done;
      en = 1'b1; baud_div = 16'd3; trans_len = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
      push(8'hF0);
      push(8'h0F);
      wait_tx_low(4, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL rstmid_start got=timeout exp=start"); end
      repeat (17) @(negedge clk);
      total++; if (tx !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_bit3 got=%b exp=0", tx); end
      rstn = 1'b0;
      #1;
      total++; if (tx !== 1'b1)         begin bad++; $display("[TB] FAIL rstmid_tx got=%b exp=1", tx); end
      total++; if (fifo_level !== 4'd0) begin bad++; $display("[TB] FAIL rstmid_level got=%0d exp=0", fifo_level); end
      total++; if (tx_busy !== 1'b0)    begin bad++; $display("[TB] FAIL rstmid_busy got=%b exp=0", tx_busy); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      seen_low  = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) seen_low = 1'b1;
         if (tx_done !== 1'b0) seen_done = 1'b1;
      end
      total++; if (seen_low)            begin bad++; $display("[TB] FAIL rstmid_no_resume got=low exp=high"); end
      total++; if (seen_done)           begin bad++; $display("[TB] FAIL rstmid_no_done got=1 exp=0"); end
      total++; if (fifo_level !== 4'd0) begin bad++; $display("[TB] FAIL rstmid_after got=%0d exp=0", fifo_level); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rstn = 1'b0; en = 1'b0; baud_div = '0; trans_len = 4'd8; parity_en = 1'b0;
      parity_type = 1'b0; stop2 = 1'b0; tx_data = '0; tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      rstn = 1'b1;
      @(negedge clk);
      test_basic_frame;
      test_parity(1'b0);
      test_parity(1'b1);
      test_fifo_full;
      test_clamp;
      test_en_drop;
      test_reset_midframe;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
